// File: rtl/adder_sum_accumulator.sv
// rtl/adder_sum_accumulator.sv - saturating batch accumulator of 9-bit adder results
module adder_sum_accumulator #(
    parameter int BATCH = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [7:0]       in_sum,
    input  logic             in_carry,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam int CNT_W = $clog2(BATCH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             res_ovf_q, res_ovf_d;

    logic [ACC_W:0]   sample;
    logic [ACC_W:0]   nxt;
    logic             sat;
    logic [ACC_W-1:0] acc_sat;
    logic             accept;
    logic             transfer;

    // One guard bit above the accumulator catches the carry that means saturation.
    assign sample  = {{(ACC_W - 8){1'b0}}, in_carry, in_sum};
    assign nxt     = {1'b0, acc_q} + sample;
    assign sat     = nxt[ACC_W];
    assign acc_sat = sat ? {ACC_W{1'b1}} : nxt[ACC_W-1:0];

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;
    assign busy      = (state_q == ST_HOLD) | (cnt_q != '0);
    assign out_sum   = sum_q;
    assign out_ovf   = res_ovf_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        res_ovf_d = res_ovf_q;
        if (clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (cnt_q == LAST_CNT) begin
                            sum_d     = acc_sat;
                            res_ovf_d = ovf_q | sat;
                            state_d   = ST_HOLD;
                            acc_d     = acc_sat;
                            ovf_d     = ovf_q | sat;
                            cnt_d     = cnt_q + 1'b1;
                        end else begin
                            acc_d = acc_sat;
                            ovf_d = ovf_q | sat;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (transfer) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            res_ovf_q <= res_ovf_d;
        end
    end
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb/tb_adder_sum_accumulator.sv - directed scoreboard bench for adder_sum_accumulator
module tb_adder_sum_accumulator;
    localparam int BATCH = 4;
    localparam int ACC_W = 10;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk;
    logic             rst;
    logic             clear;
    logic [7:0]       in_sum;
    logic             in_carry;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   m_acc;
    int   m_cnt;
    logic m_ovf;

    adder_sum_accumulator #(.BATCH(BATCH), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_sum   (in_sum),
        .in_carry (in_carry),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Called at a negedge; drives one sample, lets it be accepted, returns at the next negedge.
    task automatic send(input logic [7:0] s, input logic c, input int gap);
        exp_t e;
        int   v;
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        v = m_acc + int'({c, s});
        if (v > ACC_MAX) begin
            v     = ACC_MAX;
            m_ovf = 1'b1;
        end
        m_acc = v;
        m_cnt++;
        if (m_cnt == BATCH) begin
            e.sum = ACC_W'(m_acc);
            e.ovf = m_ovf;
            exp_q.push_back(e);
            model_reset();
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (exp_q.size() != 0)
            chk("out_valid_latency", 32'(out_valid), 32'd1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   waited;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, 32'(out_sum), 32'(e.sum));
            chk({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [ACC_W-1:0] held;
        vectors     = 0;
        miscompares = 0;
        model_reset();
        rst       = 1'b1;
        clear     = 1'b0;
        in_sum    = 8'h00;
        in_carry  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset with random inputs
        repeat (2) begin
            @(negedge clk);
            in_sum    = 8'($urandom);
            in_carry  = 1'($urandom);
            in_valid  = 1'($urandom);
            clear     = 1'($urandom);
            out_ready = 1'($urandom);
        end
        @(negedge clk);
        rst       = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);

        // Basic batch with idle gaps: 2+16+256+85 = 359
        send(8'h02, 1'b0, 1);
        chk("busy_partial", 32'(busy), 32'd1);
        send(8'h10, 1'b0, 1);
        send(8'h00, 1'b1, 1);
        send(8'h55, 1'b0, 0);
        chk("basic_in_ready_hold", 32'(in_ready), 32'd0);

        // Backpressure: in_valid asserted while result is held
        held     = out_sum;
        in_sum   = 8'hAA;
        in_carry = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_sum_stable", 32'(out_sum), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        collect("basic");
        for (int i = 0; i < 4; i++) send(8'h01, 1'b0, 0);
        collect("after_bp");

        // Saturation at ACC_W=10, then a clean batch
        for (int i = 0; i < 4; i++) send(8'hFF, 1'b1, 0);
        collect("sat");
        for (int i = 0; i < 4; i++) send(8'h01, 1'b0, 1);
        collect("post_sat");

        // Clear mid-batch
        send(8'h40, 1'b0, 0);
        send(8'h40, 1'b0, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        chk("clear_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) send(8'h03, 1'b0, 0);
        collect("after_clear");

        // Clear in HOLD with simultaneous transfer: result dropped
        for (int i = 0; i < 4; i++) send(8'h07, 1'b0, 0);
        clear     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("hold_clear_out_valid", 32'(out_valid), 32'd0);
        chk("hold_clear_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) send(8'h05, 1'b0, 0);
        collect("after_hold_clear");

        // Reset in HOLD with simultaneous transfer
        for (int i = 0; i < 4; i++) send(8'h09, 1'b1, 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("hold_rst_out_valid", 32'(out_valid), 32'd0);
        chk("hold_rst_out_sum", 32'(out_sum), 32'd0);
        chk("hold_rst_busy", 32'(busy), 32'd0);
        send(8'h80, 1'b0, 0);
        send(8'h00, 1'b0, 2);
        send(8'h7F, 1'b0, 0);
        send(8'h01, 1'b1, 0);
        collect("after_hold_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
